// File: rtl/exe_muldiv_unit_if.sv
// Bundle between the ID/EXE register / hazard logic and exe_muldiv_unit.
// Valid/ready rule: start_in is the bundle valid, and stall_out is the inverse of ready. The bundle is consumed at a rising edge where start_in=1 and stall_out=0, or where a mul/div is accepted in IDLE while stall_out=1.
interface exe_muldiv_unit_if #(
  parameter int WIDTH    = 32,
  parameter int ALU_OP_W = 6
);
  logic                start_in;
  logic [ALU_OP_W-1:0] alu_op_in;
  logic [WIDTH-1:0]    read_data_1_in;
  logic [WIDTH-1:0]    read_data_2_in;
  logic                flush_in;
  logic                busy_out;
  logic                stall_out;
  logic                done_out;
  logic                div_by_zero_out;
  logic [WIDTH-1:0]    hi_out;
  logic [WIDTH-1:0]    lo_out;
  logic [WIDTH-1:0]    result_out;
  logic [1:0]          state_dbg;

  modport master (
    output start_in, alu_op_in, read_data_1_in, read_data_2_in, flush_in,
    input  busy_out, stall_out, done_out, div_by_zero_out, hi_out, lo_out,
           result_out, state_dbg
  );

  modport slave (
    input  start_in, alu_op_in, read_data_1_in, read_data_2_in, flush_in,
    output busy_out, stall_out, done_out, div_by_zero_out, hi_out, lo_out,
           result_out, state_dbg
  );
endinterface

// File: rtl/exe_muldiv_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU unit with HI/LO and MFHI/MFLO/MTHI/MTLO.
// Optional macro MULDIV_EARLY_OUT_EN: multiply exits as soon as the remaining multiplier bits are zero.
module exe_muldiv_unit #(
  parameter int WIDTH    = 32,
  parameter int ALU_OP_W = 6
) (
  input  logic             CLK,
  input  logic             RST_N,
  exe_muldiv_unit_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [ALU_OP_W-1:0] OP_MFHI  = ALU_OP_W'('h10);
  localparam logic [ALU_OP_W-1:0] OP_MTHI  = ALU_OP_W'('h11);
  localparam logic [ALU_OP_W-1:0] OP_MFLO  = ALU_OP_W'('h12);
  localparam logic [ALU_OP_W-1:0] OP_MTLO  = ALU_OP_W'('h13);
  localparam logic [ALU_OP_W-1:0] OP_MULT  = ALU_OP_W'('h18);
  localparam logic [ALU_OP_W-1:0] OP_MULTU = ALU_OP_W'('h19);
  localparam logic [ALU_OP_W-1:0] OP_DIV   = ALU_OP_W'('h1A);
  localparam logic [ALU_OP_W-1:0] OP_DIVU  = ALU_OP_W'('h1B);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  // acc: product during MUL, {remainder, quotient} during DIV, {rs, 0} on divide-by-zero.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               zero_q, zero_d;
  logic               is_div_q, is_div_d;

  logic [ALU_OP_W-1:0] op;
  logic [WIDTH-1:0]    rs, rt;
  logic                is_mul_op, is_div_op, is_mv_op, signed_op;
  logic                a_neg, b_neg;
  logic [WIDTH-1:0]    a_abs, b_abs;
  logic                accept;
  logic [WIDTH:0]      div_shift, div_diff;
  logic [2*WIDTH-1:0]  prod_fix;
  logic [WIDTH-1:0]    quo_fix, rem_fix;
  logic                mul_exit_early;

  assign op        = bus.alu_op_in;
  assign rs        = bus.read_data_1_in;
  assign rt        = bus.read_data_2_in;
  assign is_mul_op = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div_op = (op == OP_DIV) || (op == OP_DIVU);
  assign is_mv_op  = (op == OP_MFHI) || (op == OP_MTHI) ||
                     (op == OP_MFLO) || (op == OP_MTLO);
  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg     = signed_op & rs[WIDTH-1];
  assign b_neg     = signed_op & rt[WIDTH-1];
  assign a_abs     = a_neg ? -rs : rs;
  assign b_abs     = b_neg ? -rt : rt;
  assign accept    = (state_q == S_IDLE) && bus.start_in && !bus.flush_in;

  // Restoring step: shift the next dividend bit into the partial remainder and trial-subtract.
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, mcand_q[WIDTH-1:0]};

  // Negation wraps modulo 2^WIDTH, which is what makes 0x80000000 / -1 yield 0x80000000.
  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

`ifdef MULDIV_EARLY_OUT_EN
  assign mul_exit_early = (mplier_q == '0);
`else
  assign mul_exit_early = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    zero_d    = zero_q;
    is_div_d  = is_div_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_mul_op || is_div_op) begin
            neg_d     = a_neg ^ b_neg;
            rem_neg_d = a_neg;
            cnt_d     = '0;
            is_div_d  = is_div_op;
            zero_d    = 1'b0;
            if (is_mul_op) begin
              acc_d    = '0;
              mcand_d  = {{WIDTH{1'b0}}, a_abs};
              mplier_d = b_abs;
              state_d  = S_MUL;
            end else if (rt == '0) begin
              zero_d  = 1'b1;
              acc_d   = {rs, {WIDTH{1'b0}}};
              state_d = S_FIX;
            end else begin
              acc_d   = {{WIDTH{1'b0}}, a_abs};
              mcand_d = {{WIDTH{1'b0}}, b_abs};
              state_d = S_DIV;
            end
          end else if (op == OP_MTHI) begin
            hi_d = rs;
          end else if (op == OP_MTLO) begin
            lo_d = rs;
          end
        end
      end

      S_MUL: begin
        if (bus.flush_in) begin
          state_d = S_IDLE;
        end else if (mul_exit_early) begin
          state_d = S_FIX;
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = S_FIX;
        end
      end

      S_DIV: begin
        if (bus.flush_in) begin
          state_d = S_IDLE;
        end else begin
          if (!div_diff[WIDTH])
            acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else
            acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = S_FIX;
        end
      end

      S_FIX: begin
        // Completes even under flush: the result is already committed.
        if (zero_q) begin
          hi_d = acc_q[2*WIDTH-1:WIDTH];
          lo_d = '1;
        end else if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      zero_q    <= 1'b0;
      is_div_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      zero_q    <= zero_d;
      is_div_q  <= is_div_d;
    end
  end

  assign bus.busy_out        = (state_q != S_IDLE);
  assign bus.done_out        = (state_q == S_FIX);
  assign bus.div_by_zero_out = (state_q == S_FIX) && zero_q;
  assign bus.hi_out          = hi_q;
  assign bus.lo_out          = lo_q;
  assign bus.state_dbg       = state_q;
  assign bus.stall_out       = bus.start_in &&
                               (((state_q != S_IDLE) && (is_mul_op || is_div_op || is_mv_op)) ||
                                ((state_q == S_IDLE) && (is_mul_op || is_div_op)));

  // Reads are served only from IDLE; a read during FIX is stalled and sees the value after the write.
  always_comb begin
    bus.result_out = '0;
    if ((state_q == S_IDLE) && bus.start_in) begin
      if (op == OP_MFHI)      bus.result_out = hi_q;
      else if (op == OP_MFLO) bus.result_out = lo_q;
    end
  end

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Directed bench for exe_muldiv_unit: vector table for mul/div results and latency, plus hand sequences.
module tb_exe_muldiv_unit;

  localparam int W = 32;

  localparam logic [5:0] OP_MFHI  = 6'h10;
  localparam logic [5:0] OP_MTHI  = 6'h11;
  localparam logic [5:0] OP_MFLO  = 6'h12;
  localparam logic [5:0] OP_MTLO  = 6'h13;
  localparam logic [5:0] OP_MULT  = 6'h18;
  localparam logic [5:0] OP_MULTU = 6'h19;
  localparam logic [5:0] OP_DIV   = 6'h1A;
  localparam logic [5:0] OP_DIVU  = 6'h1B;

  logic clk;
  logic rst_n;

  exe_muldiv_unit_if #(.WIDTH(W), .ALU_OP_W(6)) bus ();

  exe_muldiv_unit #(.WIDTH(W), .ALU_OP_W(6)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Present a bundle in the current cycle, note stall_out, consume it at the next edge.
  task automatic issue(input logic [5:0] op, input logic [W-1:0] rs, input logic [W-1:0] rt,
                       output logic stall_seen);
    bus.start_in       = 1'b1;
    bus.alu_op_in      = op;
    bus.read_data_1_in = rs;
    bus.read_data_2_in = rt;
    #1;
    stall_seen = bus.stall_out;
    @(posedge clk);
    #1;
    bus.start_in = 1'b0;
  endtask

  // Returns the number of edges after the accept edge at which done_out is seen high.
  task automatic wait_done(output int lat, output logic dbz, output logic ok);
    lat = 0; dbz = 1'b0; ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.done_out) begin
        lat = k; dbz = bus.div_by_zero_out; ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [W-1:0] rs;
    logic [W-1:0] rt;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
    int         exp_lat;
    logic       exp_dbz;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic stall_seen, dbz, ok;
    int lat, cycles, errs;
    logic [63:0] exp;

    vecs[0]  = '{"multu_max",  OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32, 1'b0};
    vecs[1]  = '{"mult_m3x7",  OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 32, 1'b0};
    vecs[2]  = '{"div_m7d2",   OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 32, 1'b0};
    vecs[3]  = '{"divu_100d7", OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       32, 1'b0};
    vecs[4]  = '{"div_by0",    OP_DIV,   32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF, 0,  1'b1};
    vecs[5]  = '{"div_ovf",    OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 32, 1'b0};
    vecs[6]  = '{"mult_minsq", OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'd0,        32, 1'b0};
    vecs[7]  = '{"div_7dm2",   OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 32, 1'b0};
    vecs[8]  = '{"divu_maxd1", OP_DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 32, 1'b0};
    vecs[9]  = '{"multu_sh4",  OP_MULTU, 32'h12345678, 32'h10,       32'd1,        32'h23456780, 32, 1'b0};
    vecs[10] = '{"divu_small", OP_DIVU,  32'd5,        32'h10,       32'd5,        32'd0,        32, 1'b0};
    vecs[11] = '{"mult_m1m1",  OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1,        32, 1'b0};

    rst_n = 1'b0;
    bus.start_in = 1'b0; bus.alu_op_in = '0; bus.read_data_1_in = '0;
    bus.read_data_2_in = '0; bus.flush_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_busy", bus.busy_out, 0);
    check("reset_done", bus.done_out, 0);
    check("reset_hilo", {bus.hi_out, bus.lo_out}, 0);
    check("reset_stall_result", {bus.stall_out, bus.result_out}, 0);

    // ---------------- vector table ----------------
    foreach (vecs[i]) begin
      exp_q.push_back({vecs[i].exp_hi, vecs[i].exp_lo});
      issue(vecs[i].op, vecs[i].rs, vecs[i].rt, stall_seen);
      check({vecs[i].name, "_stall_accept"}, stall_seen, 1);
      wait_done(lat, dbz, ok);
      check({vecs[i].name, "_done_seen"}, ok, 1);
      check({vecs[i].name, "_latency"}, lat, vecs[i].exp_lat);
      check({vecs[i].name, "_dbz"}, dbz, vecs[i].exp_dbz);
      @(negedge clk);
      exp = exp_q.pop_front();
      check({vecs[i].name, "_hilo"}, {bus.hi_out, bus.lo_out}, exp);
      check({vecs[i].name, "_idle"}, {bus.busy_out, bus.done_out}, 0);
    end

    // ---------------- MTHI / MFHI / MTLO / MFLO ----------------
    issue(OP_MTHI, 32'hA5A5A5A5, 32'd0, stall_seen);
    check("mthi_stall", stall_seen, 0);
    bus.start_in = 1'b1; bus.alu_op_in = OP_MFHI;
    @(negedge clk);
    check("mfhi_result", bus.result_out, 32'hA5A5A5A5);
    check("mfhi_stall", bus.stall_out, 0);
    bus.start_in = 1'b0;
    issue(OP_MTLO, 32'h5A5A0001, 32'd0, stall_seen);
    bus.start_in = 1'b1; bus.alu_op_in = OP_MFLO;
    @(negedge clk);
    check("mflo_result", bus.result_out, 32'h5A5A0001);
    bus.start_in = 1'b0;
    @(negedge clk);
    check("mflo_nostart", bus.result_out, 0);

    // ---------------- MFLO while MUL busy ----------------
    issue(OP_MULTU, 32'd3, 32'd5, stall_seen);
    bus.start_in = 1'b1; bus.alu_op_in = OP_MFLO;
    cycles = 0; errs = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!bus.busy_out) break;
      cycles++;
      if (!bus.stall_out || bus.result_out != 0) errs++;
    end
    check("mflo_busy_stall_cycles", cycles, 33);
    check("mflo_busy_errs", errs, 0);
    check("mflo_after_mul", {bus.stall_out, bus.result_out}, {1'b0, 32'd15});
    bus.start_in = 1'b0;

    // ---------------- flush mid-DIVU ----------------
    issue(OP_MTHI, 32'h11111111, 32'd0, stall_seen);
    issue(OP_MTLO, 32'h22222222, 32'd0, stall_seen);
    issue(OP_DIVU, 32'd100, 32'd7, stall_seen);
    repeat (10) @(posedge clk);
    #1 bus.flush_in = 1'b1;
    @(posedge clk);
    #1 bus.flush_in = 1'b0;
    @(negedge clk);
    check("flush_idle", bus.busy_out, 0);
    errs = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done_out) errs++;
    end
    check("flush_no_done", errs, 0);
    check("flush_hilo", {bus.hi_out, bus.lo_out}, {32'h11111111, 32'h22222222});

    // ---------------- flush during FIX still writes ----------------
    issue(OP_MULTU, 32'd6, 32'd7, stall_seen);
    wait_done(lat, dbz, ok);
    check("fixflush_done_seen", ok, 1);
    bus.flush_in = 1'b1;
    @(posedge clk);
    #1 bus.flush_in = 1'b0;
    @(negedge clk);
    check("fixflush_hilo", {bus.hi_out, bus.lo_out}, {32'd0, 32'd42});
    check("fixflush_idle", bus.busy_out, 0);

    // ---------------- flush blocks accept ----------------
    bus.flush_in = 1'b1;
    issue(OP_MULTU, 32'd9, 32'd9, stall_seen);
    bus.flush_in = 1'b0;
    @(negedge clk);
    check("acceptflush_idle", bus.busy_out, 0);
    check("acceptflush_hilo", {bus.hi_out, bus.lo_out}, {32'd0, 32'd42});

    // ---------------- unknown op ----------------
    bus.start_in = 1'b1; bus.alu_op_in = 6'h20;
    #1;
    check("unk_stall_result", {bus.stall_out, bus.result_out}, 0);
    @(posedge clk);
    #1 bus.start_in = 1'b0;
    @(negedge clk);
    check("unk_idle", bus.busy_out, 0);

    // ---------------- reset mid-MUL ----------------
    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, stall_seen);
    repeat (5) @(negedge clk);
    check("pre_reset_busy", bus.busy_out, 1);
    rst_n = 1'b0;
    #1;
    check("rst_busy_done_dbz", {bus.busy_out, bus.done_out, bus.div_by_zero_out}, 0);
    check("rst_hilo", {bus.hi_out, bus.lo_out}, 0);
    check("rst_stall_result", {bus.stall_out, bus.result_out}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", bus.busy_out, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
